// File: rtl/cargador_banco_pkg.sv
// Shared constants and FSM encoding for the register-file loader.
// The state codes stay as plain 3-bit constants so legacy probes keep decoding them.
package banco_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int BYTE_W     = 8;

    typedef logic [2:0] estado_t;

    localparam estado_t ST_IDLE  = 3'd0;
    localparam estado_t ST_RECV  = 3'd1;
    localparam estado_t ST_WRITE = 3'd2;
    localparam estado_t ST_DONE  = 3'd3;
    localparam estado_t ST_ERROR = 3'd4;

endpackage

// File: rtl/cargador_banco_ensamblador.sv
// Byte-to-word shifter: packs four bytes MSB-first and flags the byte that completes a word.
// The completed word is presented combinationally so the loader can latch it on the same edge.
module ensamblador_palabra
    import banco_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic [BYTE_W-1:0] byteIn,
    output logic [DATA_W-1:0] word,
    output logic              wordValid
);

    logic [1:0]        byteCnt;
    logic [DATA_W-1:0] shiftReg;

    assign word      = {shiftReg[DATA_W-BYTE_W-1:0], byteIn};
    assign wordValid = take && (byteCnt == 2'd3);

    // The counter wraps 3->0 on its own, so consecutive words need no explicit clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byteCnt  <= '0;
            shiftReg <= '0;
        end else if (take) begin
            byteCnt  <= byteCnt + 2'd1;
            shiftReg <= word;
        end
    end

endmodule

// File: rtl/cargador_banco.sv
// Run-time loader for the 32x32 register file: receives a byte stream and writes
// one assembled word per register through the file's write port.
module cargador_banco
    import banco_pkg::*;
#(
    parameter int START_REG  = 0,
    parameter int NUM_REGS   = 32,
    parameter int WRITE_ZERO = 0,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    output logic                  RegWrite,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int LAST_REG = (START_REG + NUM_REGS > REG_COUNT) ? REG_COUNT - 1
                                                                 : START_REG + NUM_REGS - 1;

    localparam logic [REG_ADDR_W-1:0] START_IDX = REG_ADDR_W'(START_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);
    localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]         TMO_MAX   = TW'(TIMEOUT);

    estado_t               state;
    logic [REG_ADDR_W-1:0] index;
    logic [TW-1:0]         tmoCnt;

    logic                  take;
    logic                  startOk;
    logic                  abortTmo;
    logic [DATA_W-1:0]     word;
    logic                  wordValid;

    assign byte_ready = (state == ST_RECV);
    assign busy       = (state != ST_IDLE) && (state != ST_ERROR);
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);

    assign take     = byte_ready && byte_valid;
    assign startOk  = start && ((state == ST_IDLE) || (state == ST_ERROR));
    assign abortTmo = (state == ST_RECV) && !take && (tmoCnt == TMO_LAST);

    ensamblador_palabra uEnsamblador (
        .clk       (clk),
        .reset     (reset),
        .clear     (startOk || abortTmo),
        .take      (take),
        .byteIn    (byte_in),
        .word      (word),
        .wordValid (wordValid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            index         <= '0;
            tmoCnt        <= '0;
            WriteRegister <= '0;
            WriteData     <= '0;
            RegWrite      <= 1'b0;
        end else begin
            RegWrite <= 1'b0;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (startOk) begin
                        state  <= ST_RECV;
                        index  <= START_IDX;
                        tmoCnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (take) begin
                        tmoCnt <= '0;
                        // Write port is loaded on the completing byte so RegWrite lands in WRITE.
                        if (wordValid) begin
                            state         <= ST_WRITE;
                            WriteRegister <= index;
                            WriteData     <= word;
                            RegWrite      <= (index != '0) || (WRITE_ZERO != 0);
                        end
                    end else if (abortTmo) begin
                        state  <= ST_ERROR;
                        tmoCnt <= TMO_MAX;
                    end else begin
                        tmoCnt <= tmoCnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (index == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= ST_RECV;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cargador_banco.md
Name: cargador_banco

Overview:
- Serial loader that fills the 32x32 register file at run time, replacing the static Banco.mem preload.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit words, most-significant byte first.
- Drives the register file write port (WriteRegister/WriteData/RegWrite) one register at a time.
- Sits beside the datapath write-back mux; `busy` holds the CPU off the write port while loading.

Parameters:
- START_REG, 0: first register index written.
- NUM_REGS, 32: number of words loaded. Constraint: START_REG+NUM_REGS <= 32, NUM_REGS >= 1.
- WRITE_ZERO, 0: 0 means the word for register 0 is consumed but RegWrite stays low; 1 means register 0 is written.
- TIMEOUT, 1000: idle cycles allowed inside a load before aborting.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; honoured only in IDLE or ERROR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte.
- WriteRegister  output  5  register file write address.
- WriteData  output  32  register file write data.
- RegWrite  output  1  register file write enable; single-cycle pulse.
- busy  output  1  high in every state except IDLE and ERROR.
- done  output  1  one-cycle pulse when a load completes.
- error  output  1  sticky timeout flag.

Behaviour:
- Reset (synchronous, active-high), outputs:
  - byte_ready=0, RegWrite=0, WriteRegister=0, WriteData=0, busy=0, done=0, error=0.
  - Internal state=IDLE, byte count=0, index=0, timeout count=0.
- Reset asserted mid-load aborts immediately. No RegWrite is issued in the reset cycle or after it.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE / ERROR:
  - `start` -> RECV on the next cycle: index=START_REG, byte count=0, timeout count=0, error=0.
  - `start` in any other state is ignored.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid&&byte_ready; it is shifted in with word={word[23:0],byte_in}.
  - On the 4th accepted byte -> WRITE on the next cycle.
  - Timeout counter: +1 every RECV cycle with no accepted byte; cleared on each accepted byte.
  - Counter reaching TIMEOUT -> ERROR, error=1; partial word discarded, no write.
- WRITE (exactly one cycle):
  - byte_ready=0.
  - WriteRegister=index, WriteData=assembled word.
  - RegWrite=1, except when index==0 && WRITE_ZERO==0.
  - If index==START_REG+NUM_REGS-1 -> DONE; else index+1, byte count=0, -> RECV.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: error held at 1 until `start` or reset. Outputs idle (byte_ready=0, RegWrite=0).
- Latency: RegWrite rises the cycle after the 4th byte handshake. Minimum load time is 5*NUM_REGS+1 cycles after `start` when bytes arrive back-to-back.
- Output holding: WriteRegister/WriteData keep their last written values outside WRITE. RegWrite is low outside WRITE.
- Widths:
  - Index 5 bits; no wrap is possible given the parameter constraint.
  - Byte counter 2 bits.
  - Timeout counter $clog2(TIMEOUT+1) bits; saturates, never wraps.
- byte_valid while byte_ready=0: the byte is not consumed; the sender must hold it.

Decomposition:
- Shared package (banco_pkg):
  - State enum encoding.
  - Constants REG_COUNT=32, REG_ADDR_W=5, DATA_W=32.
- Natural sub-module: ensamblador_palabra, a byte-to-word shifter with its 2-bit counter and word_valid pulse.
- FSM, index and timeout counter stay in the top module.

Test Plan:
- Full load: START_REG=0, NUM_REGS=32, bytes for reg k are 0x00,0x00,0x00,k, back-to-back.
  - 31 RegWrite pulses for regs 1..31, each WriteData=k; none for reg 0.
  - done pulses at cycle 161 after start; busy=0 afterwards.
- Stalled stream: byte_valid low 3 cycles between bytes 2 and 3 of the word 0xDEADBEEF to reg 5 (START_REG=5, NUM_REGS=1).
  - Single RegWrite with WriteRegister=5, WriteData=0xDEADBEEF.
  - No error flag.
- Timeout: TIMEOUT=10, send 2 bytes, then stop.
  - error=1 exactly 10 idle cycles later; no RegWrite; busy=0.
  - A new `start` clears error.
- Reset mid-load: assert reset after the 3rd byte of reg 7.
  - Next cycle: all outputs 0, state IDLE.
  - A 4th byte offered then is not accepted (byte_ready=0).
- `start` while busy: pulse start during a load.
  - Index is not reset; the load completes with the normal count and timing.
- WRITE_ZERO=1, NUM_REGS=1, START_REG=0, word 0x12345678.
  - RegWrite=1 with WriteRegister=0, WriteData=0x12345678.
